dmem_arbiter: RTL
=================

# dmem_arbiter

Arbitrates the single-port data memory between the pipeline MEM stage (core port) and an external loader/debug master (ext port). The core has priority, and a starvation counter guarantees the ext port a slot. A lock mode gives the ext port back-to-back bursts for program/data loading. The block sits between the EX/MEM register outputs and the data memory and drives a stall back to the pipeline whenever the core is denied.

## Interface
- STARVE_LIMIT, 4, consecutive core grants allowed while ext_valid is pending; 0 gives the ext port strict priority.
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- core_mem_read  in  1  core load request
- core_mem_write  in  1  core store request
- core_addr  in  32  core byte address
- core_wdata  in  32  core store data
- core_rdata  out  32  load data; mem_rdata when the core is granted a read, else 0
- core_stall  out  1  core request present and not granted this cycle
- ext_valid  in  1  ext request valid; held with payload until ext_ready
- ext_we  in  1  1 = write, 0 = read
- ext_lock  in  1  request a burst; keeps the grant in S_EXT
- ext_addr  in  32  ext address
- ext_wdata  in  32  ext write data
- ext_ready  out  1  ext request accepted (granted) this cycle
- ext_rvalid  out  1  registered pulse; ext read data valid
- ext_rdata  out  32  registered ext read data
- mem_addr  out  32  to data memory
- mem_wdata  out  32  to data memory
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_rdata  in  32  combinational read data from memory
- debug_state  out  1  0 = S_CORE, 1 = S_EXT

## Operation
- Request and grant terms:
  - core_req = core_mem_read | core_mem_write.
  - If core_mem_read and core_mem_write are both set, the access is a write; mem_read = 0.
- S_CORE:
  - grant_ext = ext_valid & (!core_req | starve_cnt == STARVE_LIMIT).
  - grant_core = core_req & !grant_ext.
  - Next state is S_EXT iff grant_ext & ext_lock.
- S_EXT:
  - grant_ext = ext_valid; grant_core = 0.
  - Return to S_CORE when !ext_valid, or when grant_ext & !ext_lock (last beat).
- starve_cnt (3-bit minimum, wide enough for STARVE_LIMIT):
  - Clears when grant_ext, when !ext_valid, or in S_EXT.
  - Increments when ext_valid & grant_core, saturating at STARVE_LIMIT.
- Memory mux:
  - On grant_core: core address, data and read/write.
  - On grant_ext: ext_addr, ext_wdata, mem_write = ext_we, mem_read = !ext_we.
  - With no grant: all memory outputs 0.
- Handshake outputs:
  - ext_ready = grant_ext.
  - core_stall = core_req & !grant_core.
- Ext read data: on grant_ext & !ext_we, capture mem_rdata into ext_rdata; ext_rvalid = 1 on the next cycle only. ext_rdata holds its value until the next ext read.

## Timing
- Grants, the memory mux, core_stall, ext_ready and core_rdata are combinational from the current state and inputs; core access has zero added latency.
- Ext write completes at the edge ending its grant cycle. Ext read data appears 1 cycle after ext_ready.
- Reset (sampled low at a rising edge):
  - state = S_CORE, starve_cnt = 0, ext_rvalid = 0, ext_rdata = 0.
  - While reset is low, every combinational output is forced to 0 (mem_read, mem_write, core_stall, ext_ready).
- Reset mid-burst: the state returns to S_CORE, and any rvalid pending from the cycle before reset is suppressed.
- Starvation bound: with the core requesting every cycle, a pending ext request waits at most STARVE_LIMIT cycles.
- An ext read granted on the last S_EXT beat still produces ext_rvalid on the following cycle, independent of the state change.
- core_stall in S_EXT holds for the whole burst plus zero extra cycles; the core regains the memory on the cycle after exit.

## Test plan
- Core only: core load addr 0x10 with mem_rdata = 0xDEADBEEF -> core_rdata = 0xDEADBEEF the same cycle, core_stall = 0, ext_ready = 0.
- Ext idle-core read: ext_valid, ext_we = 0, addr 0x20, mem_rdata = 0x1234 -> ext_ready = 1, and the next cycle ext_rvalid = 1, ext_rdata = 0x1234.
- Starvation: core requests every cycle, ext_valid held, STARVE_LIMIT = 4 -> 4 core grants, then on cycle 5 ext_ready = 1 and core_stall = 1, then starve_cnt = 0.
- Locked burst: ext_lock = 1 for 3 writes (0x0, 0x4, 0x8) while the core requests -> debug_state = 1, core_stall = 1 for 3 cycles (lock drops on the 3rd), then core granted on cycle 4.
- Conflicting core read+write: mem_write = 1, mem_read = 0, core_wdata driven to memory.
- Reset mid-burst: reset low during S_EXT after an ext read grant -> next cycle debug_state = 0, ext_rvalid = 0, all memory strobes 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage (core port) and an external loader/debug master (ext port).
// The core has priority. A starvation counter guarantees the ext port a slot.
// Lock mode gives the ext port back-to-back bursts.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-low reset
//   core_*              MEM-stage request; core_stall is asserted when denied
//   ext_*               valid/ready master port; registered read return
//   mem_*               data memory strobes, address and data (mem_rdata is
//                       combinational)
//   debug_state         0 = S_CORE, 1 = S_EXT
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_mem_read,
  input  logic        core_mem_write,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        ext_valid,
  input  logic        ext_we,
  input  logic        ext_lock,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_ready,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        debug_state
);

  localparam int CLOG = $clog2(STARVE_LIMIT + 1);
  localparam int CW   = (CLOG > 3) ? CLOG : 3;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  localparam logic [0:0] S_CORE = 1'b0;
  localparam logic [0:0] S_EXT  = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          rvalid_q;
  logic          core_req, grant_core, grant_ext;

  // Grant and next-state decode. Holding reset low gates every grant, so
  // all strobes and handshakes are forced to 0 during reset.
  always_comb begin
    core_req   = core_mem_read | core_mem_write;
    grant_ext  = 1'b0;
    grant_core = 1'b0;
    state_nxt  = state;
    if (reset) begin
      case (state)
        S_CORE: begin
          grant_ext  = ext_valid & (!core_req | (starve_cnt == LIM));
          grant_core = core_req & !grant_ext;
          if (grant_ext && ext_lock) state_nxt = S_EXT;
        end
        default: begin
          grant_ext = ext_valid;
          // Leave on a dropped request or on the last (unlocked) beat.
          if (!ext_valid || !ext_lock) state_nxt = S_CORE;
        end
      endcase
    end
  end

  // Memory mux. A simultaneous core read+write is treated as a write.
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    core_rdata = '0;
    if (grant_core) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_write = core_mem_write;
      mem_read  = core_mem_read & !core_mem_write;
      if (core_mem_read && !core_mem_write) core_rdata = mem_rdata;
    end else if (grant_ext) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_write = ext_we;
      mem_read  = !ext_we;
    end
  end

  assign ext_ready   = grant_ext;
  assign core_stall  = core_req & !grant_core & reset;
  // Gate with reset so a return pending from the cycle before reset is hidden.
  assign ext_rvalid  = rvalid_q & reset;
  assign debug_state = state[0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_CORE;
      starve_cnt <= '0;
      rvalid_q   <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ext || !ext_valid || state == S_EXT)
        starve_cnt <= '0;
      else if (grant_core && starve_cnt != LIM)
        starve_cnt <= starve_cnt + 1'b1;
      // rvalid follows the grant state-independently, so a read on the
      // final S_EXT beat still returns data.
      rvalid_q <= grant_ext & !ext_we;
      if (grant_ext && !ext_we) ext_rdata <= mem_rdata;
    end
  end

endmodule
